// File: rtl/mem_arbiter.sv
// Round-robin arbiter that shares the single 128x8 memory port between instruction fetch (port 0)
// and load/store (port 1), sequencing the en/read/write handshake and guarding against a hung memory.
module mem_arbiter #(
    parameter int ADDR_WIDTH = 7,
    parameter int DATA_WIDTH = 8,
    parameter int TIMEOUT    = 15
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  p0_req,
    input  logic                  p1_req,
    input  logic                  p0_we,
    input  logic                  p1_we,
    input  logic [ADDR_WIDTH-1:0] p0_addr,
    input  logic [ADDR_WIDTH-1:0] p1_addr,
    input  logic [DATA_WIDTH-1:0] p0_wdata,
    input  logic [DATA_WIDTH-1:0] p1_wdata,
    output logic                  p0_ack,
    output logic                  p1_ack,
    output logic [DATA_WIDTH-1:0] p0_rdata,
    output logic [DATA_WIDTH-1:0] p1_rdata,
    output logic                  err,
    output logic                  grant,
    output logic                  busy,
    output logic                  mem_en,
    output logic                  mem_read,
    output logic                  mem_write,
    output logic [ADDR_WIDTH-1:0] mem_address,
    output logic [DATA_WIDTH-1:0] mem_input_data,
    input  logic [DATA_WIDTH-1:0] mem_output_data,
    input  logic                  mem_ready
);

    localparam int CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        RELEASE
    } state_t;

    state_t           state;
    logic             last_served;
    logic [CNT_W-1:0] issue_cnt;

    logic                  pick_p1;
    logic                  sel_we;
    logic [ADDR_WIDTH-1:0] sel_addr;
    logic [DATA_WIDTH-1:0] sel_wdata;
    logic                  timed_out;

    // On a tie the port that was not served last wins.
    assign pick_p1   = p1_req && (!p0_req || !last_served);
    assign sel_we    = pick_p1 ? p1_we    : p0_we;
    assign sel_addr  = pick_p1 ? p1_addr  : p0_addr;
    assign sel_wdata = pick_p1 ? p1_wdata : p0_wdata;
    assign timed_out = (TIMEOUT != 0) && (issue_cnt == CNT_LAST);

    // The mem_* registers double as the latched request fields, so they stay stable through ISSUE.
    always_ff @(posedge clk) begin
        if (reset) begin
            state          <= IDLE;
            last_served    <= 1'b1;
            issue_cnt      <= '0;
            grant          <= 1'b0;
            busy           <= 1'b0;
            p0_ack         <= 1'b0;
            p1_ack         <= 1'b0;
            err            <= 1'b0;
            p0_rdata       <= '0;
            p1_rdata       <= '0;
            mem_en         <= 1'b0;
            mem_read       <= 1'b0;
            mem_write      <= 1'b0;
            mem_address    <= '0;
            mem_input_data <= '0;
        end else begin
            p0_ack <= 1'b0;
            p1_ack <= 1'b0;
            err    <= 1'b0;
            case (state)
                IDLE: begin
                    if (p0_req || p1_req) begin
                        grant          <= pick_p1;
                        busy           <= 1'b1;
                        mem_en         <= 1'b1;
                        mem_read       <= ~sel_we;
                        mem_write      <= sel_we;
                        mem_address    <= sel_addr;
                        mem_input_data <= sel_wdata;
                        issue_cnt      <= '0;
                        state          <= ISSUE;
                    end
                end
                ISSUE: begin
                    if (mem_ready || timed_out) begin
                        if (mem_ready && !mem_write) begin
                            if (grant) begin
                                p1_rdata <= mem_output_data;
                            end else begin
                                p0_rdata <= mem_output_data;
                            end
                        end
                        err       <= ~mem_ready;
                        p0_ack    <= ~grant;
                        p1_ack    <= grant;
                        mem_en    <= 1'b0;
                        mem_read  <= 1'b0;
                        mem_write <= 1'b0;
                        state     <= RELEASE;
                    end else if (issue_cnt != '1) begin
                        issue_cnt <= issue_cnt + 1'b1;
                    end
                end
                RELEASE: begin
                    last_served    <= grant;
                    busy           <= 1'b0;
                    mem_address    <= '0;
                    mem_input_data <= '0;
                    state          <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Randomized scoreboard bench for mem_arbiter: a transaction-level model predicts grant order,
// memory contents and per-port read data; a monitor checks each issue and each ack against it.
module tb_mem_arbiter;

    localparam int TO = 4;

    typedef struct {
        bit         req;
        bit         we;
        logic [6:0] addr;
        logic [7:0] wdata;
        int         delay;
        bit         scr;
    } txn_t;

    typedef struct {
        int         port;
        bit         we;
        logic [6:0] addr;
        logic [7:0] wdata;
        bit         to;
        int         cycles;
        logic [7:0] rd0;
        logic [7:0] rd1;
    } exp_t;

    logic       clk = 1'b0;
    logic       reset;
    logic       p0_req, p1_req, p0_we, p1_we;
    logic [6:0] p0_addr, p1_addr;
    logic [7:0] p0_wdata, p1_wdata;
    logic       p0_ack, p1_ack, err, grant, busy;
    logic [7:0] p0_rdata, p1_rdata;
    logic       mem_en, mem_read, mem_write;
    logic [6:0] mem_address;
    logic [7:0] mem_input_data;
    logic [7:0] mem_output_data = 8'h00;
    logic       mem_ready = 1'b0;

    int   n_compared   = 0;
    int   n_mismatched = 0;
    exp_t exp_q[$];
    int   delay_q[$];
    int   last_served = 1;
    logic [7:0] ref_mem [128];
    logic [7:0] mem_array [128];
    logic [7:0] model_rd [2];
    bit   mon_hold = 1'b1;

    mem_arbiter #(.ADDR_WIDTH(7), .DATA_WIDTH(8), .TIMEOUT(TO)) dut (
        .clk(clk), .reset(reset),
        .p0_req(p0_req), .p1_req(p1_req), .p0_we(p0_we), .p1_we(p1_we),
        .p0_addr(p0_addr), .p1_addr(p1_addr), .p0_wdata(p0_wdata), .p1_wdata(p1_wdata),
        .p0_ack(p0_ack), .p1_ack(p1_ack), .p0_rdata(p0_rdata), .p1_rdata(p1_rdata),
        .err(err), .grant(grant), .busy(busy),
        .mem_en(mem_en), .mem_read(mem_read), .mem_write(mem_write),
        .mem_address(mem_address), .mem_input_data(mem_input_data),
        .mem_output_data(mem_output_data), .mem_ready(mem_ready)
    );

    always #5 clk = ~clk;

    task automatic check_output(input string name, input int act, input int exp);
        n_compared++;
        if (act !== exp) begin
            n_mismatched++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Transaction-level reference: a write lands in memory, a read refreshes that port's rdata, a timeout does neither.
    function automatic void predict(input int port, input txn_t t);
        exp_t e;
        e.port   = port;
        e.we     = t.we;
        e.addr   = t.addr;
        e.wdata  = t.wdata;
        e.to     = (t.delay < 0);
        e.cycles = e.to ? TO : t.delay;
        if (!e.to) begin
            if (t.we) ref_mem[t.addr] = t.wdata;
            else model_rd[port] = ref_mem[t.addr];
        end
        e.rd0 = model_rd[0];
        e.rd1 = model_rd[1];
        exp_q.push_back(e);
        delay_q.push_back(t.delay);
        last_served = port;
    endfunction

    function automatic txn_t mk(input bit req, input bit we, input int addr, input int wdata,
                                input int delay, input bit scr);
        txn_t t;
        t.req   = req;
        t.we    = we;
        t.addr  = 7'(addr);
        t.wdata = 8'(wdata);
        t.delay = delay;
        t.scr   = scr;
        return t;
    endfunction

    function automatic int rand_delay();
        if ($urandom_range(0, 5) == 0) return -1;
        return int'($urandom_range(1, 3));
    endfunction

    // Memory stand-in: answers after the planned number of en-high cycles, and throws stray ready pulses while en is low.
    int en_k = 0;
    int cur_delay = -1;
    always @(negedge clk) begin
        if (mem_en) begin
            en_k++;
            if (en_k == 1) begin
                cur_delay = -1;
                if (delay_q.size() > 0) cur_delay = delay_q.pop_front();
            end
            if (en_k == cur_delay) begin
                mem_ready = 1'b1;
                if (mem_write) begin
                    mem_array[mem_address] = mem_input_data;
                    mem_output_data = 8'($urandom);
                end else begin
                    mem_output_data = mem_array[mem_address];
                end
            end else begin
                mem_ready = 1'b0;
                mem_output_data = 8'($urandom);
            end
        end else begin
            en_k = 0;
            mem_ready = ($urandom_range(0, 3) == 0);
            mem_output_data = 8'($urandom);
        end
    end

    // Monitor: checks the memory request at each en rise and the completion at each ack against the scoreboard.
    bit   prev_en = 1'b0;
    bit   prev_ack = 1'b0;
    int   en_cnt = 0;
    exp_t cur;
    always @(negedge clk) begin
        if (mon_hold) begin
            prev_en  = 1'b0;
            prev_ack = 1'b0;
            en_cnt   = 0;
        end else begin
            if (prev_ack) check_output("ack_one_cycle", int'({p0_ack, p1_ack}), 0);
            if (mem_en && !prev_en) begin
                en_cnt = 1;
                if (exp_q.size() == 0) begin
                    n_compared++;
                    n_mismatched++;
                    $display("[TB] FAIL unexpected_issue: got mem_en=1 addr=0x%0h, expected no transaction", mem_address);
                end else begin
                    cur = exp_q[0];
                    check_output("issue_grant", int'(grant), cur.port);
                    check_output("issue_busy", int'(busy), 1);
                    check_output("issue_write", int'(mem_write), int'(cur.we));
                    check_output("issue_read", int'(mem_read), int'(!cur.we));
                    check_output("issue_addr", int'(mem_address), int'(cur.addr));
                    if (cur.we) check_output("issue_wdata", int'(mem_input_data), int'(cur.wdata));
                end
            end else if (mem_en) begin
                en_cnt++;
                check_output("addr_stable", int'(mem_address), int'(cur.addr));
                check_output("write_stable", int'(mem_write), int'(cur.we));
            end
            if (p0_ack || p1_ack) begin
                if (exp_q.size() == 0) begin
                    n_compared++;
                    n_mismatched++;
                    $display("[TB] FAIL unexpected_ack: got acks=%b, expected none", {p0_ack, p1_ack});
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    check_output("ack_port", int'({p0_ack, p1_ack}), (e.port == 0) ? 2 : 1);
                    check_output("ack_err", int'(err), int'(e.to));
                    check_output("ack_en_low", int'(mem_en), 0);
                    check_output("ack_busy", int'(busy), 1);
                    check_output("issue_cycles", en_cnt, e.cycles);
                    check_output("p0_rdata", int'(p0_rdata), int'(e.rd0));
                    check_output("p1_rdata", int'(p1_rdata), int'(e.rd1));
                end
            end else begin
                check_output("err_without_ack", int'(err), 0);
            end
            prev_en  = mem_en;
            prev_ack = p0_ack || p1_ack;
        end
    end

    // One arbitration round: raise the requested ports, drop each req at its ack, optionally scramble the granted port mid-ISSUE.
    task automatic apply_stimulus(input txn_t t0, input txn_t t1);
        int ord[2];
        int n;
        int got;
        bit scrambled[2];
        @(negedge clk);
        n = 0;
        if (t0.req && t1.req) begin
            ord[0] = (last_served == 1) ? 0 : 1;
            ord[1] = 1 - ord[0];
            n = 2;
        end else if (t0.req) begin
            ord[0] = 0;
            n = 1;
        end else if (t1.req) begin
            ord[0] = 1;
            n = 1;
        end
        for (int i = 0; i < n; i++) predict(ord[i], (ord[i] == 0) ? t0 : t1);
        p0_req = t0.req; p0_we = t0.we; p0_addr = t0.addr; p0_wdata = t0.wdata;
        p1_req = t1.req; p1_we = t1.we; p1_addr = t1.addr; p1_wdata = t1.wdata;
        got = 0;
        scrambled[0] = 1'b0;
        scrambled[1] = 1'b0;
        for (int b = 0; b < 80 && got < n; b++) begin
            @(negedge clk);
            if (p0_ack) begin p0_req = 1'b0; got++; end
            if (p1_ack) begin p1_req = 1'b0; got++; end
            if (got < n && mem_en && !scrambled[ord[got]]) begin
                if (ord[got] == 0 && t0.scr) begin
                    p0_addr = p0_addr ^ 7'($urandom_range(1, 127));
                    p0_wdata = ~p0_wdata; p0_we = ~p0_we; p0_req = 1'b0;
                    scrambled[0] = 1'b1;
                end else if (ord[got] == 1 && t1.scr) begin
                    p1_addr = p1_addr ^ 7'($urandom_range(1, 127));
                    p1_wdata = ~p1_wdata; p1_we = ~p1_we; p1_req = 1'b0;
                    scrambled[1] = 1'b1;
                end
            end
        end
        if (got < n) begin
            check_output("round_complete", got, n);
            p0_req = 1'b0;
            p1_req = 1'b0;
        end
    endtask

    task automatic reset_mid_issue();
        int b;
        @(negedge clk);
        predict(0, mk(1, 0, 3, 0, -1, 0));
        p0_req = 1'b1; p0_we = 1'b0; p0_addr = 7'd3;
        for (b = 0; b < 20 && !mem_en; b++) @(negedge clk);
        check_output("reset_test_issue", int'(mem_en), 1);
        @(negedge clk);
        reset = 1'b1;
        mon_hold = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        p0_req = 1'b0;
        check_output("rst_mem_en", int'(mem_en), 0);
        check_output("rst_mem_rw", int'({mem_read, mem_write}), 0);
        check_output("rst_mem_addr", int'(mem_address), 0);
        check_output("rst_acks", int'({p0_ack, p1_ack, err}), 0);
        check_output("rst_busy_grant", int'({busy, grant}), 0);
        check_output("rst_rdata", int'({p0_rdata, p1_rdata}), 0);
        exp_q.delete();
        delay_q.delete();
        last_served = 1;
        model_rd[0] = 8'h00;
        model_rd[1] = 8'h00;
        @(negedge clk);
        mon_hold = 1'b0;
        repeat (3) begin
            @(negedge clk);
            check_output("no_ack_after_reset", int'({p0_ack, p1_ack, err, mem_en}), 0);
        end
    endtask

    task automatic check_reset_state();
        check_output("reset_mem_ctrl", int'({mem_en, mem_read, mem_write}), 0);
        check_output("reset_mem_addr_data", int'({mem_address, mem_input_data}), 0);
        check_output("reset_ack_err", int'({p0_ack, p1_ack, err}), 0);
        check_output("reset_grant_busy", int'({grant, busy}), 0);
        check_output("reset_p0_rdata", int'(p0_rdata), 0);
        check_output("reset_p1_rdata", int'(p1_rdata), 0);
    endtask

    initial begin
        for (int i = 0; i < 128; i++) begin
            ref_mem[i] = 8'h00;
            mem_array[i] = 8'h00;
        end
        model_rd[0] = 8'h00;
        model_rd[1] = 8'h00;
        reset = 1'b1;
        p0_req = 1'b0; p0_we = 1'b0; p0_addr = '0; p0_wdata = '0;
        p1_req = 1'b0; p1_we = 1'b0; p1_addr = '0; p1_wdata = '0;
        repeat (3) @(negedge clk);
        check_reset_state();
        reset = 1'b0;
        @(negedge clk);
        mon_hold = 1'b0;

        $display("[TB] directed: single write, read-back, contention, timeout");
        apply_stimulus(mk(1, 1, 1, 8'hFF, 2, 0), mk(0, 0, 0, 0, 1, 0));
        apply_stimulus(mk(0, 0, 0, 0, 1, 0), mk(1, 0, 1, 0, 1, 0));
        repeat (2) apply_stimulus(mk(1, 1, 2, 8'hA5, 1, 0), mk(1, 0, 2, 0, 3, 0));
        apply_stimulus(mk(1, 0, 1, 0, -1, 0), mk(0, 0, 0, 0, 1, 0));

        $display("[TB] directed: reset mid-ISSUE, then fresh p1 request");
        reset_mid_issue();
        apply_stimulus(mk(0, 0, 0, 0, 1, 0), mk(1, 0, 1, 0, 2, 0));

        $display("[TB] directed: field change after grant");
        apply_stimulus(mk(1, 1, 5, 8'h3C, 3, 1), mk(0, 0, 0, 0, 1, 0));

        $display("[TB] randomized rounds");
        for (int r = 0; r < 40; r++) begin
            int pat;
            pat = int'($urandom_range(1, 3));
            apply_stimulus(
                mk(pat[0], 1'($urandom), int'($urandom_range(0, 7)), int'($urandom), rand_delay(),
                   $urandom_range(0, 3) == 0),
                mk(pat[1], 1'($urandom), int'($urandom_range(0, 7)), int'($urandom), rand_delay(),
                   $urandom_range(0, 3) == 0));
        end

        repeat (4) @(negedge clk);
        check_output("scoreboard_drained", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: got simulation still running, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
